// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer between the ADC capture stage and the spectrum stage.
// Samples are gathered into FRAME_LEN-long frames and streamed out over valid/ready.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// W_FILL   | write side storing strobes into its bank
// W_FULL   | write bank complete, waiting for the read side; strobes dropped
// R_IDLE   | read side has no frame, o_valid low
// R_STREAM | read side presenting its bank, one beat per accepted handshake
module audio_frame_buffer #(
   parameter int FRAME_LEN = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic [15:0] i_sample,
   input  logic        i_sample_valid,
   output logic [15:0] o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_last,
   output logic        o_overflow,
   output logic [15:0] o_drop_cnt,
   output logic [15:0] o_frame_cnt
);

   localparam int PTR_W = $clog2(FRAME_LEN);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

   typedef enum logic {W_FILL, W_FULL} w_state_t;
   typedef enum logic {R_IDLE, R_STREAM} r_state_t;

   logic [15:0]      r_mem [0:2*FRAME_LEN-1];
   w_state_t         r_wstate, w_wstate_nxt;
   r_state_t         r_rstate, w_rstate_nxt;
   logic [PTR_W-1:0] r_wptr, w_wptr_nxt;
   logic [PTR_W-1:0] r_rptr, w_rptr_nxt;
   logic             r_wbank, w_wbank_nxt;
   logic             r_overflow;
   logic [15:0]      r_drop_cnt;
   logic [15:0]      r_frame_cnt;

   logic w_strobe, w_stream, w_last, w_beat, w_beat_last, w_read_free;
   logic w_store, w_frame_done, w_handoff, w_drop;

   assign w_strobe     = i_enable & i_sample_valid;
   assign w_stream     = (r_rstate == R_STREAM);
   assign w_last       = w_stream && (r_rptr == LAST_IDX);
   assign w_beat       = w_stream && i_ready;
   assign w_beat_last  = w_beat && w_last;
   // Read bank is free now, or frees up this cycle as its last beat leaves.
   assign w_read_free  = (r_rstate == R_IDLE) || w_beat_last;
   assign w_store      = (r_wstate == W_FILL) && w_strobe;
   assign w_frame_done = w_store && (r_wptr == LAST_IDX);
   assign w_handoff    = (w_frame_done || (r_wstate == W_FULL)) && w_read_free;
   assign w_drop       = (r_wstate == W_FULL) && w_strobe;

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wptr_nxt   = r_wptr;
      w_wbank_nxt  = r_wbank;
      w_rstate_nxt = r_rstate;
      w_rptr_nxt   = r_rptr;

      case (r_wstate)
         W_FILL: begin
            if (!i_enable) begin
               w_wptr_nxt = '0;
            end else if (w_store) begin
               if (w_frame_done) begin
                  w_wptr_nxt = '0;
                  if (!w_handoff) w_wstate_nxt = W_FULL;
               end else begin
                  w_wptr_nxt = r_wptr + 1'b1;
               end
            end
         end
         W_FULL: begin
            if (w_read_free) w_wstate_nxt = W_FILL;
         end
         default: w_wstate_nxt = W_FILL;
      endcase

      if (w_handoff) w_wbank_nxt = ~r_wbank;

      case (r_rstate)
         R_IDLE: begin
            if (w_handoff) begin
               w_rstate_nxt = R_STREAM;
               w_rptr_nxt   = '0;
            end
         end
         R_STREAM: begin
            if (w_beat) begin
               if (w_last) begin
                  w_rptr_nxt = '0;
                  if (!w_handoff) w_rstate_nxt = R_IDLE;
               end else begin
                  w_rptr_nxt = r_rptr + 1'b1;
               end
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wstate    <= W_FILL;
         r_rstate    <= R_IDLE;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_wbank     <= 1'b0;
         r_overflow  <= 1'b0;
         r_drop_cnt  <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
         r_wptr   <= w_wptr_nxt;
         r_rptr   <= w_rptr_nxt;
         r_wbank  <= w_wbank_nxt;
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         end
         if (w_handoff) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   // Bank storage carries no reset; contents are only read after being written.
   always_ff @(posedge i_clk) begin
      if (w_store) r_mem[{r_wbank, r_wptr}] <= i_sample;
   end

   assign o_valid     = w_stream;
   assign o_last      = w_last;
   assign o_data      = w_stream ? r_mem[{~r_wbank, r_rptr}] : 16'h0000;
   assign o_overflow  = r_overflow;
   assign o_drop_cnt  = r_drop_cnt;
   assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Bench for audio_frame_buffer: phase table with hand-derived end states, a queue-based
// frame model checked every cycle, plus stall, random and mid-stream reset sequences.
module tb_audio_frame_buffer;

   localparam int FL = 64;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_enable = 1'b0;
   logic [15:0] i_sample = 16'h0;
   logic        i_sample_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_last;
   logic        o_overflow;
   logic [15:0] o_drop_cnt;
   logic [15:0] o_frame_cnt;

   always #5 clk = ~clk;

   audio_frame_buffer #(.FRAME_LEN(FL)) dut (
      .i_clk          (clk),
      .i_rst_n        (i_rst_n),
      .i_enable       (i_enable),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_data         (o_data),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_last         (o_last),
      .o_overflow     (o_overflow),
      .o_drop_cnt     (o_drop_cnt),
      .o_frame_cnt    (o_frame_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   typedef logic [15:0] smp_t;

   // Reference model: frames as queues of samples
   smp_t        m_partial[$];
   smp_t        m_pending[$];
   smp_t        m_stream[$];
   bit          m_full;
   bit          m_ovf;
   int          m_drop;
   logic [15:0] m_frames;

   typedef struct {
      int          n;
      bit          rst_n;
      bit          en;
      bit          sv;
      logic [15:0] base;
      bit          rdy;
      bit          e_valid;
      logic [15:0] e_data;
      bit          e_last;
      bit          e_ovf;
      logic [15:0] e_drop;
      logic [15:0] e_frames;
   } row_t;

   row_t tbl[$];

   task automatic model_reset();
      m_partial.delete();
      m_pending.delete();
      m_stream.delete();
      m_full   = 1'b0;
      m_ovf    = 1'b0;
      m_drop   = 0;
      m_frames = 16'h0;
   endtask

   task automatic check_model();
      bit   ev;
      bit   el;
      smp_t ed;
      ev = (m_stream.size() > 0);
      el = ev && (m_stream.size() == 1);
      ed = 16'h0;
      if (ev) ed = m_stream[0];
      vectors++;
      if (o_valid !== ev || (ev && o_data !== ed) || o_last !== el || o_overflow !== m_ovf ||
          o_drop_cnt !== 16'(m_drop) || o_frame_cnt !== m_frames) begin
         miscompares++;
         $display("FAIL model t=%0t valid=%b/%b data=%h/%h last=%b/%b ovf=%b/%b drop=%0d/%0d frames=%0d/%0d (actual/expected)",
                  $time, o_valid, ev, o_data, ed, o_last, el, o_overflow, m_ovf,
                  o_drop_cnt, m_drop, o_frame_cnt, m_frames);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit en, input bit sv,
                             input logic [15:0] s, input bit rdy);
      bit busy;
      bit accept_last;
      bit free;
      if (!rst_n) begin
         model_reset();
         return;
      end
      busy        = (m_stream.size() > 0);
      accept_last = busy && rdy && (m_stream.size() == 1);
      free        = !busy || accept_last;
      if (busy && rdy) void'(m_stream.pop_front());
      if (!m_full) begin
         if (!en) begin
            m_partial.delete();
         end else if (sv) begin
            m_partial.push_back(s);
            if (m_partial.size() == FL) begin
               if (free) begin
                  m_stream = m_partial;
                  m_frames++;
               end else begin
                  m_pending = m_partial;
                  m_full    = 1'b1;
               end
               m_partial.delete();
            end
         end
      end else begin
         if (en && sv) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end
         if (free) begin
            m_stream = m_pending;
            m_pending.delete();
            m_full = 1'b0;
            m_frames++;
         end
      end
   endtask

   task automatic cyc(input bit rst_n, input bit en, input bit sv,
                      input logic [15:0] s, input bit rdy);
      i_rst_n        = rst_n;
      i_enable       = en;
      i_sample_valid = sv;
      i_sample       = s;
      i_ready        = rdy;
      @(negedge clk);
      check_model();
      model_step(rst_n, en, sv, s, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input int n, input bit rst_n, input bit en, input bit sv,
                      input logic [15:0] base, input bit rdy, input bit ev,
                      input logic [15:0] ed, input bit el, input bit eo,
                      input logic [15:0] edrop, input logic [15:0] efr);
      row_t r;
      r.n = n; r.rst_n = rst_n; r.en = en; r.sv = sv; r.base = base; r.rdy = rdy;
      r.e_valid = ev; r.e_data = ed; r.e_last = el; r.e_ovf = eo;
      r.e_drop = edrop; r.e_frames = efr;
      tbl.push_back(r);
   endtask

   initial begin
      bit          rdy;
      bit          cv;
      bit          cl;
      logic [15:0] cd;
      int          acc;

      //  n   rst en sv base     rdy | valid data     last ovf drop frames
      add(2,  0, 0, 0, 16'h0000, 0,    0, 16'h0000, 0,   0, 0,   0);
      add(64, 1, 1, 1, 16'h0000, 1,    1, 16'h0000, 0,   0, 0,   1);
      add(63, 1, 1, 0, 16'h0000, 1,    1, 16'h003F, 1,   0, 0,   1);
      add(1,  1, 1, 0, 16'h0000, 1,    0, 16'h0000, 0,   0, 0,   1);
      add(64, 1, 1, 1, 16'h0100, 0,    1, 16'h0100, 0,   0, 0,   2);
      add(64, 1, 1, 1, 16'h0200, 0,    1, 16'h0100, 0,   0, 0,   2);
      add(64, 1, 1, 1, 16'h0300, 0,    1, 16'h0100, 0,   1, 64,  2);
      add(64, 1, 1, 0, 16'h0000, 1,    1, 16'h0200, 0,   1, 64,  3);
      add(64, 1, 1, 0, 16'h0000, 1,    0, 16'h0000, 0,   1, 64,  3);
      add(1,  0, 0, 0, 16'h0000, 0,    0, 16'h0000, 0,   0, 0,   0);
      add(20, 1, 1, 1, 16'h0500, 1,    0, 16'h0000, 0,   0, 0,   0);
      add(1,  1, 0, 1, 16'h0600, 1,    0, 16'h0000, 0,   0, 0,   0);
      add(64, 1, 1, 1, 16'h1000, 1,    1, 16'h1000, 0,   0, 0,   1);
      add(64, 1, 1, 0, 16'h0000, 1,    0, 16'h0000, 0,   0, 0,   1);
      add(64, 1, 1, 1, 16'h2000, 0,    1, 16'h2000, 0,   0, 0,   2);
      add(64, 1, 1, 1, 16'h3000, 1,    1, 16'h3000, 0,   0, 0,   3);
      add(64, 1, 1, 0, 16'h0000, 1,    0, 16'h0000, 0,   0, 0,   3);

      repeat (2) @(posedge clk);
      #1;
      model_reset();

      foreach (tbl[r]) begin
         for (int i = 0; i < tbl[r].n; i++)
            cyc(tbl[r].rst_n, tbl[r].en, tbl[r].sv, 16'(tbl[r].base + 16'(i)), tbl[r].rdy);
         chk($sformatf("row%0d_valid", r), {15'b0, o_valid}, {15'b0, tbl[r].e_valid});
         if (tbl[r].e_valid || !tbl[r].rst_n)
            chk($sformatf("row%0d_data", r), o_data, tbl[r].e_data);
         chk($sformatf("row%0d_last", r), {15'b0, o_last}, {15'b0, tbl[r].e_last});
         chk($sformatf("row%0d_ovf", r), {15'b0, o_overflow}, {15'b0, tbl[r].e_ovf});
         chk($sformatf("row%0d_drop", r), o_drop_cnt, tbl[r].e_drop);
         chk($sformatf("row%0d_frames", r), o_frame_cnt, tbl[r].e_frames);
      end

      // Random back-pressure during one frame: stable outputs while stalled, in-order beats
      for (int i = 0; i < FL; i++) cyc(1, 1, 1, 16'(16'h4000 + i), 0);
      acc = 0;
      for (int k = 0; k < 2000 && acc < FL; k++) begin
         rdy = 1'($urandom_range(0, 1));
         cv  = o_valid;
         cd  = o_data;
         cl  = o_last;
         cyc(1, 1, 0, 16'h0, rdy);
         if (cv && rdy) begin
            chk("stall_order", cd, 16'(16'h4000 + acc));
            chk("stall_last", {15'b0, cl}, {15'b0, (acc == FL - 1)});
            acc++;
         end else if (cv) begin
            chk("stall_hold_valid", {15'b0, o_valid}, 16'd1);
            chk("stall_hold_data", o_data, cd);
            chk("stall_hold_last", {15'b0, o_last}, {15'b0, cl});
         end
      end
      chk("stall_beats", 16'(acc), 16'(FL));

      // Random traffic against the model
      for (int k = 0; k < 3000; k++)
         cyc(1, ($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 70),
             16'($urandom), ($urandom_range(0, 99) < 40));

      // Drain, then reset in the middle of a frame at beat 30
      for (int k = 0; k < 200; k++) cyc(1, 0, 0, 16'h0, 1);
      chk("drain_idle", {15'b0, o_valid}, 16'd0);
      for (int i = 0; i < FL; i++) cyc(1, 1, 1, 16'(16'h5000 + i), 1);
      for (int i = 0; i < 30; i++) cyc(1, 1, 0, 16'h0, 1);
      chk("mid_beat30", o_data, 16'h501E);
      cyc(0, 1, 0, 16'h0, 1);
      chk("mid_rst_valid", {15'b0, o_valid}, 16'd0);
      chk("mid_rst_last", {15'b0, o_last}, 16'd0);
      chk("mid_rst_data", o_data, 16'h0000);
      chk("mid_rst_ovf", {15'b0, o_overflow}, 16'd0);
      chk("mid_rst_drop", o_drop_cnt, 16'd0);
      chk("mid_rst_frames", o_frame_cnt, 16'd0);
      for (int i = 0; i < FL; i++) cyc(1, 1, 1, 16'(16'h6000 + i), 1);
      chk("fresh_valid", {15'b0, o_valid}, 16'd1);
      chk("fresh_data0", o_data, 16'h6000);
      for (int i = 0; i < FL; i++) cyc(1, 1, 0, 16'h0, 1);
      chk("fresh_done", {15'b0, o_valid}, 16'd0);
      chk("fresh_frames", o_frame_cnt, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
